display_rx: RTL

- Receiving end of the serial display link driven by display_out: deserialises the `data_out`/`data_ready` bit stream into a 4-digit BCD word.
- Drives a time-multiplexed 4-digit 7-segment display from that word.
- Sits on the display board (or in the loopback bench) on the same `LF_int_osc` clock domain as the transmitter.
- Flags malformed frames and keeps the last good word on display.

---
 rtl/calc_pkg.sv | 56 +++++
 rtl/bcd_to_7seg.sv | 26 ++
 rtl/display_rx.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator display path.
//   - Digit geometry: NUM_DIGITS, BCD_W, DEF_FRAME_BITS (default frame length).
//   - Active-high 7-segment patterns, bit order {g,f,e,d,c,b,a}.
//   - Receive FSM state type and encoding for the serial display link.
//   - bcd_seg_pattern(): nibble -> active-high segment pattern.
// -----------------------------------------------------------------------------
package calc_pkg;

   localparam int NUM_DIGITS     = 4;
   localparam int BCD_W          = 4;
   localparam int DEF_FRAME_BITS = 16;

   // Segment patterns, {g,f,e,d,c,b,a}, 1 = segment lit
   localparam logic [6:0] SEG_0     = 7'b0111111;
   localparam logic [6:0] SEG_1     = 7'b0000110;
   localparam logic [6:0] SEG_2     = 7'b1011011;
   localparam logic [6:0] SEG_3     = 7'b1001111;
   localparam logic [6:0] SEG_4     = 7'b1100110;
   localparam logic [6:0] SEG_5     = 7'b1101101;
   localparam logic [6:0] SEG_6     = 7'b1111101;
   localparam logic [6:0] SEG_7     = 7'b0000111;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1101111;
   localparam logic [6:0] SEG_DASH  = 7'b1000000;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   // Receive FSM encoding, kept as plain constants so older tools and
   // netlists see fixed state codes.
   typedef logic [1:0] rx_state_t;
   localparam rx_state_t RX_IDLE  = 2'd0;
   localparam rx_state_t RX_SHIFT = 2'd1;
   localparam rx_state_t RX_CHECK = 2'd2;

   // Decimal digits get their usual glyph; anything above 9 is not a valid
   // BCD digit, so it is shown as a dash rather than a misleading hex glyph.
   function automatic logic [6:0] bcd_seg_pattern(input logic [BCD_W-1:0] nibble);
      logic [6:0] pattern;
      case (nibble)
         4'd0:    pattern = SEG_0;
         4'd1:    pattern = SEG_1;
         4'd2:    pattern = SEG_2;
         4'd3:    pattern = SEG_3;
         4'd4:    pattern = SEG_4;
         4'd5:    pattern = SEG_5;
         4'd6:    pattern = SEG_6;
         4'd7:    pattern = SEG_7;
         4'd8:    pattern = SEG_8;
         4'd9:    pattern = SEG_9;
         default: pattern = SEG_DASH;
      endcase
      return pattern;
   endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// -----------------------------------------------------------------------------
// bcd_to_7seg
// Combinational BCD nibble to active-high 7-segment decoder with blanking.
// Ports:
//   nibble  in  4  BCD digit (A-F decode to a dash)
//   blank   in  1  force all segments off
//   seg     out 7  active-high segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module bcd_to_7seg
   import calc_pkg::*;
(
   input  logic [BCD_W-1:0] nibble,
   input  logic             blank,
   output logic [6:0]       seg
);

   // Blank takes priority so callers can suppress a digit without caring
   // what value happens to be on the nibble.
   always_comb begin
      seg = SEG_BLANK;
      if (!blank) begin
         seg = bcd_seg_pattern(nibble);
      end
   end

endmodule

// File: rtl/display_rx.sv
// -----------------------------------------------------------------------------
// display_rx
// Receiving end of the serial display link. Deserialises the MSB-first
// data_in/data_ready stream into a 4-digit BCD word, flags malformed frames,
// and scans the last good word onto a multiplexed 4-digit 7-segment display.
//
// Optional build macro:
//   DISP_RX_ZERO_BLANK_EN  leading-zero blanking on digits 3..1
//
// Parameters:
//   FRAME_BITS      bits per frame (4 BCD nibbles)
//   SCAN_DIV        clk cycles each digit stays lit
//   SEG_ACTIVE_LOW  1 = seg/an active-low (common anode), 0 = active-high
//
// Ports:
//   clk          in   1  system clock (same domain as transmitter)
//   rst          in   1  asynchronous reset, active-high
//   data_in      in   1  serial bit from transmitter
//   data_ready   in   1  high during every valid bit cycle of a frame
//   bcd_out      out 16  last accepted frame, [3:0] = least-significant digit
//   frame_valid  out  1  one-cycle pulse when bcd_out updates
//   frame_err    out  1  sticky bad-frame flag, cleared by next good frame
//   seg          out  7  segments {g,f,e,d,c,b,a}
//   an           out  4  one-hot digit enables, an[0] = rightmost digit
// -----------------------------------------------------------------------------
module display_rx
   import calc_pkg::*;
#(
   parameter int FRAME_BITS     = DEF_FRAME_BITS,
   parameter int SCAN_DIV       = 25,
   parameter bit SEG_ACTIVE_LOW = 1'b1
)(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        data_in,
   input  logic                        data_ready,
   output logic [NUM_DIGITS*BCD_W-1:0] bcd_out,
   output logic                        frame_valid,
   output logic                        frame_err,
   output logic [6:0]                  seg,
   output logic [NUM_DIGITS-1:0]       an
);

   localparam int WORD_W = NUM_DIGITS * BCD_W;
   localparam int CNT_W  = $clog2(FRAME_BITS + 2);
   localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   // XOR masks applied only at the output registers; everything upstream
   // of them is active-high.
   localparam logic [6:0]            SEG_POL = {7{SEG_ACTIVE_LOW}};
   localparam logic [NUM_DIGITS-1:0] AN_POL  = {NUM_DIGITS{SEG_ACTIVE_LOW}};

   rx_state_t         rx_state;
   logic [WORD_W-1:0] shreg;
   logic [CNT_W-1:0]  bit_cnt;

   logic [DIV_W-1:0]      div_cnt;
   logic [1:0]            digit_sel;
   logic [BCD_W-1:0]      cur_nibble;
   logic [NUM_DIGITS-1:0] blank_mask;
   logic                  cur_blank;
   logic [6:0]            seg_hi;
   logic [NUM_DIGITS-1:0] an_hi;

   // Receive FSM. A frame is a run of data_ready cycles; SHIFT seeing
   // data_ready low is the falling edge. The accept/reject verdict is
   // registered on that edge so bcd_out/frame_valid are visible during the
   // CHECK cycle, exactly one clk after the last bit. bit_cnt saturates one
   // past a full frame so an overrun can never alias onto a good length.
   // IDLE and CHECK both start a new frame on data_ready, which is what
   // lets back-to-back frames get by with a single idle cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state    <= RX_IDLE;
         shreg       <= '0;
         bit_cnt     <= '0;
         bcd_out     <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         case (rx_state)
            RX_IDLE, RX_CHECK: begin
               if (data_ready) begin
                  shreg    <= {shreg[WORD_W-2:0], data_in};
                  bit_cnt  <= CNT_W'(1);
                  rx_state <= RX_SHIFT;
               end else begin
                  rx_state <= RX_IDLE;
               end
            end
            RX_SHIFT: begin
               if (data_ready) begin
                  shreg <= {shreg[WORD_W-2:0], data_in};
                  if (bit_cnt != CNT_SAT) begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  if (bit_cnt == CNT_FULL) begin
                     bcd_out     <= shreg;
                     frame_valid <= 1'b1;
                     frame_err   <= 1'b0;
                  end else begin
                     frame_err   <= 1'b1;
                  end
                  bit_cnt  <= '0;
                  rx_state <= RX_CHECK;
               end
            end
            default: begin
               rx_state <= RX_IDLE;
               bit_cnt  <= '0;
            end
         endcase
      end
   end

   // Scan timebase: each digit stays lit for SCAN_DIV clocks, then the
   // 2-bit digit select wraps naturally 3 -> 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt   <= '0;
         digit_sel <= '0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt   <= '0;
         digit_sel <= digit_sel + 2'd1;
      end else begin
         div_cnt   <= div_cnt + 1'b1;
      end
   end

`ifdef DISP_RX_ZERO_BLANK_EN
   // Leading-zero blanking: walk down from the most-significant digit and
   // keep blanking while every digit seen so far is zero. Digit 0 is never
   // blanked so an all-zero word still shows "0".
   always_comb begin
      logic still_zero;
      blank_mask = '0;
      still_zero = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         still_zero    = still_zero && (bcd_out[i*BCD_W +: BCD_W] == '0);
         blank_mask[i] = still_zero;
      end
   end
`else
   // Without blanking every digit is always shown.
   assign blank_mask = '0;
`endif

   assign cur_nibble = bcd_out[32'(digit_sel) * BCD_W +: BCD_W];
   assign cur_blank  = blank_mask[digit_sel];
   assign an_hi      = NUM_DIGITS'(1) << digit_sel;

   bcd_to_7seg u_bcd_to_7seg (
      .nibble (cur_nibble),
      .blank  (cur_blank),
      .seg    (seg_hi)
   );

   // Registered display outputs, polarity applied here only. Reset drives
   // everything to the "off" level for the selected polarity.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg <= SEG_POL;
         an  <= AN_POL;
      end else begin
         seg <= seg_hi ^ SEG_POL;
         an  <= an_hi ^ AN_POL;
      end
   end

endmodule
